axi2mem_tcdm_engine: RTL and testbench



---
 rtl/axi2mem_pkg.sv | 25 ++
 rtl/axi2mem_tcdm_resp_fifo.sv | 67 ++++++
 rtl/axi2mem_tcdm_engine.sv | 223 ++++++++++++++++++++++
 tb/tb_axi2mem_tcdm_engine.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi2mem_pkg.sv
// Shared definitions for the axi2mem TCDM engine: lane geometry, engine
// FSM state encoding and the per-lane address helper.
package axi2mem_pkg;

  localparam int TCDM_LANES = 2;
  localparam int BEAT_BYTES = 8;
  localparam int LANE_BYTES = 4;

  // Engine FSM state, also exported on the debug port of the top.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_WRITE   = 2'd2,
    ST_WR_RESP = 2'd3
  } eng_state_e;

  // Byte address of beat 'cnt' on lane 'lane': base + 8*cnt + 4*lane,
  // silently wrapping at 2^32.
  function automatic logic [31:0] lane_addr(input logic [31:0] base,
                                            input logic [8:0]  cnt,
                                            input logic        lane);
    return base + {20'd0, cnt, 3'd0} + {29'd0, lane, 2'd0};
  endfunction

endpackage

// File: rtl/axi2mem_tcdm_resp_fifo.sv
// Per-lane read response FIFO. Head entry is presented from the registered
// storage; output data reads as zero while the FIFO is empty.
module axi2mem_tcdm_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_CNT);
  assign valid_o = (count_q != '0);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && valid_o;
  assign dout_o  = valid_o ? mem_q[rptr_q] : '0;

  // Storage write; contents need no reset because valid_o gates the output.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= (wptr_q == LAST_PTR) ? '0 : wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q <= (rptr_q == LAST_PTR) ? '0 : rptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Read credits upstream guarantee a free slot for every returning beat.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full));

endmodule

// File: rtl/axi2mem_tcdm_engine.sv
// TCDM-side engine of the axi2mem bridge. One burst at a time; every 64-bit
// beat is split over two independent 32-bit TCDM lanes (low word on lane 0,
// high word on lane 1). Reads are credit-limited so the per-lane response
// FIFO can never overflow; writes stream straight from the write buffers.
//
// Handshakes: every req/gnt, push_req/push_gnt, pop_gnt/pop_req and
// bresp_valid/bresp_ready pair completes a transfer in a cycle where both
// sides are high at the rising clock edge; the offering side keeps its
// request independent of the accepting side's response.
module axi2mem_tcdm_engine
  import axi2mem_pkg::*;
#(
  parameter int RESP_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // command
  input  logic             cmd_req_i,
  output logic             cmd_gnt_o,
  input  logic             cmd_we_i,
  input  logic [31:0]      cmd_add_i,
  input  logic [7:0]       cmd_len_i,
  input  logic [5:0]       cmd_id_i,
  // TCDM lanes
  output logic [1:0]       tcdm_req_o,
  output logic [1:0][31:0] tcdm_add_o,
  output logic [1:0]       tcdm_we_o,
  output logic [1:0][3:0]  tcdm_be_o,
  output logic [1:0][31:0] tcdm_wdata_o,
  input  logic [1:0]       tcdm_gnt_i,
  input  logic [1:0]       tcdm_r_valid_i,
  input  logic [1:0][31:0] tcdm_r_data_i,
  // read buffers
  output logic [1:0][31:0] rd_push_dat_o,
  output logic [1:0]       rd_push_req_o,
  input  logic [1:0]       rd_push_gnt_i,
  output logic [5:0]       rd_push_id_o,
  output logic             rd_push_last_o,
  // write buffers
  input  logic [1:0][31:0] wr_pop_dat_i,
  input  logic [1:0][3:0]  wr_pop_strb_i,
  input  logic [1:0]       wr_pop_gnt_i,
  output logic [1:0]       wr_pop_req_o,
  // write completion
  output logic             bresp_valid_o,
  output logic [5:0]       bresp_id_o,
  input  logic             bresp_ready_i,
  // debug
  output eng_state_e       dbg_state_o
);

  localparam int CRW = $clog2(RESP_DEPTH + 1);
  localparam logic [CRW-1:0] CREDIT_FULL = CRW'(RESP_DEPTH);

  eng_state_e                      state_q;
  logic                            cmd_gnt_q;
  logic                            bresp_valid_q;
  logic [31:0]                     base_q;
  logic [7:0]                      len_q;
  logic [5:0]                      id_q;
  logic [7:0]                      rd_idx_q;
  logic [TCDM_LANES-1:0][8:0]      cnt_q;
  logic [TCDM_LANES-1:0][CRW-1:0]  credit_q;

  logic [TCDM_LANES-1:0]           done;
  logic [TCDM_LANES-1:0]           last_beat;
  logic [TCDM_LANES-1:0]           gnt_hs;
  logic [TCDM_LANES-1:0]           rd_gnt;
  logic [TCDM_LANES-1:0]           fin;
  logic [TCDM_LANES-1:0]           push_hs;
  logic [TCDM_LANES-1:0]           credit_full;
  logic [TCDM_LANES-1:0]           fifo_push;

  assign cmd_gnt_o      = cmd_gnt_q;
  assign bresp_valid_o  = bresp_valid_q;
  assign bresp_id_o     = id_q;
  assign rd_push_id_o   = id_q;
  assign rd_push_last_o = rd_push_req_o[0] && (rd_idx_q == len_q);
  assign dbg_state_o    = state_q;

  // Per-lane progress, handshake and credit status.
  always_comb begin
    done        = '0;
    last_beat   = '0;
    gnt_hs      = '0;
    rd_gnt      = '0;
    fin         = '0;
    push_hs     = '0;
    credit_full = '0;
    fifo_push   = '0;
    for (int i = 0; i < TCDM_LANES; i++) begin
      done[i]        = (cnt_q[i] == ({1'b0, len_q} + 9'd1));
      last_beat[i]   = (cnt_q[i] == {1'b0, len_q});
      gnt_hs[i]      = tcdm_req_o[i] & tcdm_gnt_i[i];
      rd_gnt[i]      = gnt_hs[i] && (state_q == ST_READ);
      // Lane has issued (or is issuing this cycle) its final beat.
      fin[i]         = done[i] | (gnt_hs[i] & last_beat[i]);
      push_hs[i]     = rd_push_req_o[i] & rd_push_gnt_i[i];
      credit_full[i] = (credit_q[i] == CREDIT_FULL);
      // Responses only count while a read is live; stale ones after reset drop.
      fifo_push[i]   = tcdm_r_valid_i[i] && (state_q == ST_READ);
    end
  end

  // TCDM request generation and write-buffer pops; all zero outside a burst.
  always_comb begin
    tcdm_req_o   = '0;
    tcdm_add_o   = '0;
    tcdm_we_o    = '0;
    tcdm_be_o    = '0;
    tcdm_wdata_o = '0;
    wr_pop_req_o = '0;
    for (int i = 0; i < TCDM_LANES; i++) begin
      case (state_q)
        ST_READ: begin
          tcdm_req_o[i] = !done[i] && (credit_q[i] != '0);
          tcdm_add_o[i] = lane_addr(base_q, cnt_q[i], i[0]);
          tcdm_be_o[i]  = 4'hF;
        end
        ST_WRITE: begin
          // A beat with an all-zero strobe is still issued to keep lanes aligned.
          tcdm_req_o[i]   = !done[i] && wr_pop_gnt_i[i];
          tcdm_add_o[i]   = lane_addr(base_q, cnt_q[i], i[0]);
          tcdm_we_o[i]    = 1'b1;
          tcdm_be_o[i]    = wr_pop_strb_i[i];
          tcdm_wdata_o[i] = wr_pop_dat_i[i];
          wr_pop_req_o[i] = tcdm_req_o[i] & tcdm_gnt_i[i];
        end
        default: ;
      endcase
    end
  end

  // Engine FSM with counters, credits and registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cmd_gnt_q     <= 1'b1;
      bresp_valid_q <= 1'b0;
      base_q        <= '0;
      len_q         <= '0;
      id_q          <= '0;
      rd_idx_q      <= '0;
      cnt_q         <= '0;
      credit_q      <= {TCDM_LANES{CREDIT_FULL}};
    end else begin
      for (int i = 0; i < TCDM_LANES; i++) begin
        if (gnt_hs[i]) begin
          cnt_q[i] <= cnt_q[i] + 9'd1;
        end
        if (rd_gnt[i] && !push_hs[i]) begin
          credit_q[i] <= credit_q[i] - CRW'(1);
        end else if (!rd_gnt[i] && push_hs[i]) begin
          credit_q[i] <= credit_q[i] + CRW'(1);
        end
      end
      if (push_hs[0]) begin
        rd_idx_q <= rd_idx_q + 8'd1;
      end

      case (state_q)
        ST_IDLE: begin
          if (cmd_req_i) begin
            base_q    <= cmd_add_i & 32'hFFFF_FFF8;
            len_q     <= cmd_len_i;
            id_q      <= cmd_id_i;
            rd_idx_q  <= '0;
            cnt_q     <= '0;
            credit_q  <= {TCDM_LANES{CREDIT_FULL}};
            cmd_gnt_q <= 1'b0;
            state_q   <= cmd_we_i ? ST_WRITE : ST_READ;
          end
        end
        ST_READ: begin
          // Finished once every beat is issued and every response pushed out.
          if ((&done) && (&credit_full)) begin
            cmd_gnt_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (&fin) begin
            bresp_valid_q <= 1'b1;
            state_q       <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (bresp_ready_i) begin
            bresp_valid_q <= 1'b0;
            cmd_gnt_q     <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // One response FIFO per lane; its head drives the read-buffer push port.
  for (genvar g = 0; g < TCDM_LANES; g++) begin : g_lane
    axi2mem_tcdm_resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .WIDTH (32)
    ) u_resp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push[g]),
      .din_i   (tcdm_r_data_i[g]),
      .pop_i   (rd_push_gnt_i[g]),
      .dout_o  (rd_push_dat_o[g]),
      .valid_o (rd_push_req_o[g])
    );
  end

  a_credit_range : assert property (@(posedge clk_i) disable iff (rst_i)
    (credit_q[0] <= CREDIT_FULL) && (credit_q[1] <= CREDIT_FULL));

  a_gnt_only_idle : assert property (@(posedge clk_i) disable iff (rst_i)
    cmd_gnt_o == (state_q == ST_IDLE));

endmodule

// File: tb/tb_axi2mem_tcdm_engine.sv
// Bench for axi2mem_tcdm_engine: a TCDM slave model answers one cycle after
// each grant, write buffers are fed from per-lane stimulus queues, and all
// addresses, read pushes and completions are checked against queues filled
// when each command is issued.
module tb_axi2mem_tcdm_engine;
  import axi2mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic             cmd_req_i, cmd_gnt_o, cmd_we_i;
  logic [31:0]      cmd_add_i;
  logic [7:0]       cmd_len_i;
  logic [5:0]       cmd_id_i;
  logic [1:0]       tcdm_req_o, tcdm_we_o, tcdm_gnt_i, tcdm_r_valid_i;
  logic [1:0][31:0] tcdm_add_o, tcdm_wdata_o, tcdm_r_data_i;
  logic [1:0][3:0]  tcdm_be_o;
  logic [1:0][31:0] rd_push_dat_o;
  logic [1:0]       rd_push_req_o, rd_push_gnt_i;
  logic [5:0]       rd_push_id_o;
  logic             rd_push_last_o;
  logic [1:0][31:0] wr_pop_dat_i;
  logic [1:0][3:0]  wr_pop_strb_i;
  logic [1:0]       wr_pop_gnt_i, wr_pop_req_o;
  logic             bresp_valid_o, bresp_ready_i;
  logic [5:0]       bresp_id_o;
  eng_state_e       dbg_state;

  axi2mem_tcdm_engine #(.RESP_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_req_i(cmd_req_i), .cmd_gnt_o(cmd_gnt_o), .cmd_we_i(cmd_we_i),
    .cmd_add_i(cmd_add_i), .cmd_len_i(cmd_len_i), .cmd_id_i(cmd_id_i),
    .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o), .tcdm_we_o(tcdm_we_o),
    .tcdm_be_o(tcdm_be_o), .tcdm_wdata_o(tcdm_wdata_o), .tcdm_gnt_i(tcdm_gnt_i),
    .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_data_i(tcdm_r_data_i),
    .rd_push_dat_o(rd_push_dat_o), .rd_push_req_o(rd_push_req_o),
    .rd_push_gnt_i(rd_push_gnt_i), .rd_push_id_o(rd_push_id_o),
    .rd_push_last_o(rd_push_last_o),
    .wr_pop_dat_i(wr_pop_dat_i), .wr_pop_strb_i(wr_pop_strb_i),
    .wr_pop_gnt_i(wr_pop_gnt_i), .wr_pop_req_o(wr_pop_req_o),
    .bresp_valid_o(bresp_valid_o), .bresp_id_o(bresp_id_o),
    .bresp_ready_i(bresp_ready_i), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_add0_q[$];
  logic [31:0] exp_add1_q[$];
  logic [32:0] exp_rd0_q[$];   // {last, data}
  logic [31:0] exp_rd1_q[$];
  logic [35:0] wr0_q[$];       // {strb, data}
  logic [35:0] wr1_q[$];

  int          cyc = 0;
  int          issue_cyc = 0;
  int          b_due = -1;
  int          push_hold = 0;
  int          gnt_start [2];
  int          n_hs [2];
  int          last_gnt [2];
  int          first_req = -1;
  int          first_push = -1;
  bit          rand_gnt = 1'b0;
  bit          rand_push = 1'b0;
  logic        cur_we = 1'b0;
  logic [5:0]  cur_id = '0;
  logic        pend_rv [2];
  logic [31:0] pend_a [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_reset_outputs();
    chk("rst_cmd_gnt",   cmd_gnt_o, 1);
    chk("rst_state",     dbg_state, ST_IDLE);
    chk("rst_tcdm_req",  tcdm_req_o, 0);
    chk("rst_tcdm_add",  tcdm_add_o, 0);
    chk("rst_tcdm_we",   tcdm_we_o, 0);
    chk("rst_tcdm_be",   tcdm_be_o, 0);
    chk("rst_tcdm_wdat", tcdm_wdata_o, 0);
    chk("rst_push_req",  rd_push_req_o, 0);
    chk("rst_push_dat",  rd_push_dat_o, 0);
    chk("rst_push_id",   rd_push_id_o, 0);
    chk("rst_push_last", rd_push_last_o, 0);
    chk("rst_pop_req",   wr_pop_req_o, 0);
    chk("rst_bvalid",    bresp_valid_o, 0);
    chk("rst_bid",       bresp_id_o, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue_cmd(input logic we, input logic [31:0] add, input logic [7:0] len,
                           input logic [5:0] id, input int strb);
    logic [31:0] a, la, d;
    logic [7:0]  s;
    cur_we = we;
    cur_id = id;
    n_hs[0] = 0; n_hs[1] = 0;
    last_gnt[0] = -1; last_gnt[1] = -1;
    first_req = -1;
    first_push = -1;
    a = add & 32'hFFFF_FFF8;
    for (int b = 0; b <= int'(len); b++) begin
      for (int l = 0; l < 2; l++) begin
        la = a + 32'(b * BEAT_BYTES) + 32'(l * LANE_BYTES);
        if (l == 0) exp_add0_q.push_back(la); else exp_add1_q.push_back(la);
        if (!we) begin
          if (l == 0) exp_rd0_q.push_back({(b == int'(len)), mem_word(la)});
          else        exp_rd1_q.push_back(mem_word(la));
        end else begin
          s = (strb < 0) ? 8'($urandom) : 8'(strb);
          d = $urandom;
          if (l == 0) wr0_q.push_back({s[3:0], d}); else wr1_q.push_back({s[7:4], d});
        end
      end
    end
    cmd_req_i = 1'b1;
    cmd_we_i  = we;
    cmd_add_i = add;
    cmd_len_i = len;
    cmd_id_i  = id;
    #1;
    chk("cmd_gnt_idle", cmd_gnt_o, 1);
    @(posedge clk);
    #1;
    cmd_req_i = 1'b0;
    issue_cyc = cyc;
  endtask

  task automatic obs_lane(input int l);
    logic [31:0] ea;
    logic [35:0] w;
    logic [32:0] r0;
    logic [31:0] r1;
    bit          empty;
    if (l == 0 && first_req < 0 && tcdm_req_o[0]) first_req = cyc;
    if (tcdm_req_o[l] && tcdm_gnt_i[l]) begin
      n_hs[l]++;
      last_gnt[l] = cyc;
      empty = (l == 0) ? (exp_add0_q.size() == 0) : (exp_add1_q.size() == 0);
      if (empty) begin
        chk("unexp_req", 1, 0);
      end else begin
        if (l == 0) ea = exp_add0_q.pop_front(); else ea = exp_add1_q.pop_front();
        chk("tcdm_add", tcdm_add_o[l], ea);
        chk("tcdm_we", tcdm_we_o[l], cur_we);
        if (cur_we) begin
          chk("wr_pop_req", wr_pop_req_o[l], 1);
          if ((l == 0 && wr0_q.size() == 0) || (l == 1 && wr1_q.size() == 0)) begin
            chk("unexp_wr", 1, 0);
          end else begin
            if (l == 0) w = wr0_q.pop_front(); else w = wr1_q.pop_front();
            chk("tcdm_be", tcdm_be_o[l], w[35:32]);
            chk("tcdm_wdata", tcdm_wdata_o[l], w[31:0]);
          end
          if (exp_add0_q.size() == 0 && exp_add1_q.size() == 0) b_due = cyc + 1;
        end else begin
          chk("tcdm_be_rd", tcdm_be_o[l], 4'hF);
          chk("wr_pop_req_rd", wr_pop_req_o[l], 0);
          pend_rv[l] = 1'b1;
          pend_a[l]  = ea;
        end
      end
    end
    if (rd_push_req_o[l] && rd_push_gnt_i[l]) begin
      if (l == 0) begin
        if (first_push < 0) first_push = cyc;
        if (exp_rd0_q.size() == 0) chk("unexp_push0", 1, 0);
        else begin
          r0 = exp_rd0_q.pop_front();
          chk("rd_dat0", rd_push_dat_o[0], r0[31:0]);
          chk("rd_last", rd_push_last_o, r0[32]);
          chk("rd_id", rd_push_id_o, cur_id);
        end
      end else begin
        if (exp_rd1_q.size() == 0) chk("unexp_push1", 1, 0);
        else begin
          r1 = exp_rd1_q.pop_front();
          chk("rd_dat1", rd_push_dat_o[1], r1);
        end
      end
    end
  endtask

  // One clock cycle: drive all responder inputs at the falling edge, then
  // observe handshakes that will complete on the next rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int l = 0; l < 2; l++) begin
      tcdm_r_valid_i[l] = pend_rv[l];
      tcdm_r_data_i[l]  = pend_rv[l] ? mem_word(pend_a[l]) : 32'h0;
      pend_rv[l]        = 1'b0;
      tcdm_gnt_i[l]     = (cyc >= gnt_start[l]) && (!rand_gnt || ($urandom_range(0, 1) == 1));
    end
    if (push_hold > 0) begin
      rd_push_gnt_i = 2'b00;
      push_hold--;
    end else begin
      rd_push_gnt_i = rand_push ? 2'($urandom_range(0, 3)) : 2'b11;
    end
    wr_pop_gnt_i[0]  = (wr0_q.size() > 0);
    wr_pop_dat_i[0]  = (wr0_q.size() > 0) ? wr0_q[0][31:0] : 32'h0;
    wr_pop_strb_i[0] = (wr0_q.size() > 0) ? wr0_q[0][35:32] : 4'h0;
    wr_pop_gnt_i[1]  = (wr1_q.size() > 0);
    wr_pop_dat_i[1]  = (wr1_q.size() > 0) ? wr1_q[0][31:0] : 32'h0;
    wr_pop_strb_i[1] = (wr1_q.size() > 0) ? wr1_q[0][35:32] : 4'h0;
    bresp_ready_i    = (b_due >= 0) && (cyc >= b_due + 2);
    #1;
    chk("bresp_valid", bresp_valid_o, (b_due >= 0) && (cyc >= b_due));
    if (bresp_valid_o && bresp_ready_i) begin
      chk("bresp_id", bresp_id_o, cur_id);
      b_due = -1;
    end
    obs_lane(0);
    obs_lane(1);
  endtask

  task automatic wait_done(input int budget);
    int  k;
    bit  fin;
    k = 0;
    fin = 1'b0;
    while (!fin && k < budget) begin
      step();
      k++;
      fin = cmd_gnt_o && (b_due < 0) && exp_add0_q.size() == 0 && exp_add1_q.size() == 0 &&
            exp_rd0_q.size() == 0 && exp_rd1_q.size() == 0;
    end
    if (!fin) chk("timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cmd_req_i = 0; cmd_we_i = 0; cmd_add_i = 0; cmd_len_i = 0; cmd_id_i = 0;
    tcdm_gnt_i = 0; tcdm_r_valid_i = 0; tcdm_r_data_i = '0;
    rd_push_gnt_i = 0; wr_pop_dat_i = '0; wr_pop_strb_i = '0; wr_pop_gnt_i = 0;
    bresp_ready_i = 0;
    gnt_start[0] = 0; gnt_start[1] = 0;
    pend_rv[0] = 0; pend_rv[1] = 0;
    pend_a[0] = 0; pend_a[1] = 0;
    n_hs[0] = 0; n_hs[1] = 0;
    last_gnt[0] = -1; last_gnt[1] = -1;

    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    check_reset_outputs();
    step();

    // Read 0x1000, 4 beats, always granted; command ignored while busy.
    issue_cmd(1'b0, 32'h0000_1000, 8'd3, 6'h15, -1);
    step();
    chk("gnt_busy", cmd_gnt_o, 0);
    cmd_req_i = 1'b1; cmd_id_i = 6'h3F; cmd_we_i = 1'b1;
    step();
    chk("gnt_busy_req", cmd_gnt_o, 0);
    step();
    cmd_req_i = 1'b0;
    wait_done(60);
    chk("first_req_lat", first_req - issue_cyc, 1);
    chk("first_push_lat", first_push - issue_cyc, 3);
    chk("pushes_lane0", n_hs[0], 4);

    // Read 8 beats with the read buffers stalled: credits cap issue at 4/lane.
    issue_cmd(1'b0, 32'h0000_2040, 8'd7, 6'h2A, -1);
    push_hold = 10;
    repeat (10) step();
    chk("credit_stall0", n_hs[0], 4);
    chk("credit_stall1", n_hs[1], 4);
    wait_done(80);
    chk("credit_total0", n_hs[0], 8);

    // Write 2 beats, lane 1 grant held off for three cycles.
    gnt_start[1] = cyc + 4;
    issue_cmd(1'b1, 32'h0000_3000, 8'd1, 6'h07, -1);
    wait_done(60);
    gnt_start[1] = 0;
    chk("lane0_first", last_gnt[0] < last_gnt[1], 1);
    chk("lane1_last_gnt", last_gnt[1] - issue_cyc, 5);

    // Write with only the low half strobed: lane 1 still issues be=0000.
    issue_cmd(1'b1, 32'h0000_4008, 8'd1, 6'h11, 8'h0F);
    wait_done(60);
    chk("zero_be_lane1_issued", n_hs[1], 2);

    // Address wrap past 2^32.
    issue_cmd(1'b0, 32'hFFFF_FFF8, 8'd1, 6'h22, -1);
    wait_done(60);

    // Random grants and read-buffer backpressure, mixed bursts.
    rand_gnt = 1'b1;
    rand_push = 1'b1;
    for (int t = 0; t < 6; t++) begin
      issue_cmd(1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 6)),
                6'($urandom), -1);
      wait_done(300);
    end
    rand_gnt = 1'b0;
    rand_push = 1'b0;

    // Reset in the middle of a read; the response of the last grant arrives after.
    issue_cmd(1'b0, 32'h0000_5000, 8'd7, 6'h33, -1);
    repeat (3) step();
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    exp_add0_q.delete(); exp_add1_q.delete();
    exp_rd0_q.delete();  exp_rd1_q.delete();
    wr0_q.delete();      wr1_q.delete();
    b_due = -1;
    check_reset_outputs();
    step();
    step();
    chk("stale_push", rd_push_req_o, 0);
    step();
    chk("stale_push2", rd_push_req_o, 0);

    // Engine works normally after the reset.
    issue_cmd(1'b0, 32'h0000_6000, 8'd1, 6'h05, -1);
    wait_done(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
